// File: rtl/mult_div_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
`timescale 1ns/1ps
package mult_div_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int CNT_W_DEF  = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MULT    = 2'd1,
    DIV     = 2'd2,
    DIV_FIX = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    BOOTH_NOP = 2'd0,
    BOOTH_ADD = 2'd1,
    BOOTH_SUB = 2'd2
  } booth_op_t;

  // Radix-2 Booth recoding of the multiplier LSB and the bit shifted out last cycle.
  function automatic booth_op_t booth_decode(input logic lo0, input logic q_m1);
    booth_op_t op;
    case ({lo0, q_m1})
      2'b10:   op = BOOTH_SUB;
      2'b01:   op = BOOTH_ADD;
      default: op = BOOTH_NOP;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// Start strobes, operands, result buses and completion flags of the multiply/divide unit.
`timescale 1ns/1ps
interface mult_div_if import mult_div_pkg::*; #(parameter int DATA_W = DATA_W_DEF);

  logic              mult_control;
  logic              div_control;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic [DATA_W-1:0] mult_hi;
  logic [DATA_W-1:0] mult_lo;
  logic [DATA_W-1:0] div_hi;
  logic [DATA_W-1:0] div_lo;
  logic              mult_stop;
  logic              div_stop;
  logic              div_zero;
  logic              busy;

  modport master (
    output mult_control, div_control, a_in, b_in,
    input  mult_hi, mult_lo, div_hi, div_lo, mult_stop, div_stop, div_zero, busy
  );

  modport slave (
    input  mult_control, div_control, a_in, b_in,
    output mult_hi, mult_lo, div_hi, div_lo, mult_stop, div_stop, div_zero, busy
  );

endinterface

// File: rtl/mult_div_unit_div_core.sv
// Restoring divider on operand magnitudes with a combinational sign fix on the way out.
`timescale 1ns/1ps
module div_core #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  logic [DATA_W-1:0] rem;
  logic [DATA_W-1:0] quo;
  logic [DATA_W:0]   dvsr;
  logic              q_neg;
  logic              r_neg;
  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] diff;

  // One extra bit keeps |most negative value| exact instead of wrapping.
  function automatic logic [DATA_W:0] magnitude(input logic [DATA_W-1:0] v);
    logic [DATA_W:0] ext;
    ext = {v[DATA_W-1], v};
    if (ext[DATA_W])
      return -ext;
    return ext;
  endfunction

  // Trial subtraction: shift in the next dividend bit and test against the divisor.
  always_comb begin
    shifted = {rem, quo[DATA_W-1]};
    fits    = (shifted >= dvsr);
    diff    = DATA_W'(shifted - dvsr);
  end

  // Load magnitudes and signs on start, then produce one quotient bit per step.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem   <= '0;
      quo   <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (load) begin
      rem   <= '0;
      quo   <= DATA_W'(magnitude(dividend));
      dvsr  <= magnitude(divisor);
      q_neg <= dividend[DATA_W-1] ^ divisor[DATA_W-1];
      r_neg <= dividend[DATA_W-1];
    end else if (step) begin
      rem   <= fits ? diff : shifted[DATA_W-1:0];
      quo   <= {quo[DATA_W-2:0], fits};
    end
  end

  // Truncating division: quotient negative on sign mismatch, remainder follows the dividend.
  always_comb begin
    quotient  = q_neg ? -quo : quo;
    remainder = r_neg ? -rem : rem;
  end

endmodule

// File: rtl/mult_div_unit.sv
// Sequential signed multiplier (radix-2 Booth) and divider (restoring) sharing one control FSM.
`timescale 1ns/1ps
module mult_div_unit import mult_div_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic     clk,
  input  logic     reset,
  mult_div_if.slave bus
);

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  count;
  logic              last_iter;
  logic              b_zero;
  logic              mult_start;
  logic              div_start;
  logic              zero_start;
  logic              mult_step;
  logic              div_step;
  logic              mult_done;
  logic              div_done;
  logic              busy;

  logic [DATA_W:0]   acc_hi;
  logic [DATA_W:0]   acc_hi_next;
  logic [DATA_W:0]   booth_sum;
  logic [DATA_W:0]   mcand_ext;
  logic [DATA_W-1:0] acc_lo;
  logic [DATA_W-1:0] acc_lo_next;
  logic [DATA_W-1:0] mcand;
  logic              q_m1;

  logic [DATA_W-1:0] quotient;
  logic [DATA_W-1:0] remainder;
  logic [DATA_W-1:0] mult_hi_q;
  logic [DATA_W-1:0] mult_lo_q;
  logic [DATA_W-1:0] div_hi_q;
  logic [DATA_W-1:0] div_lo_q;
  logic              mult_stop_q;
  logic              div_stop_q;
  logic              div_zero_q;

  assign last_iter = (count == CNT_W'(DATA_W - 1));
  assign b_zero    = (bus.b_in == '0);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_next;
  end

  // Next state: multiply wins a simultaneous start, divide by zero never leaves IDLE.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (bus.mult_control)
          state_next = MULT;
        else if (bus.div_control && !b_zero)
          state_next = DIV;
      end
      MULT:    if (last_iter) state_next = IDLE;
      DIV:     if (last_iter) state_next = DIV_FIX;
      DIV_FIX: state_next = IDLE;
    endcase
  end

  // Control strobes decoded from the current state and the start inputs.
  always_comb begin
    mult_start = 1'b0;
    div_start  = 1'b0;
    zero_start = 1'b0;
    mult_step  = 1'b0;
    div_step   = 1'b0;
    mult_done  = 1'b0;
    div_done   = 1'b0;
    busy       = (state != IDLE);
    unique case (state)
      IDLE: begin
        mult_start = bus.mult_control;
        div_start  = !bus.mult_control && bus.div_control && !b_zero;
        zero_start = !bus.mult_control && bus.div_control && b_zero;
      end
      MULT: begin
        mult_step = 1'b1;
        mult_done = last_iter;
      end
      DIV:     div_step = 1'b1;
      DIV_FIX: div_done = 1'b1;
    endcase
  end

  // Iteration counter, cleared on start and wrapped back to zero after the last iteration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      count <= '0;
    else if (mult_start || div_start)
      count <= '0;
    else if (mult_step || div_step)
      count <= last_iter ? '0 : count + 1'b1;
  end

  // Booth step; the hi half carries a guard bit so subtracting the most negative multiplicand cannot overflow.
  always_comb begin
    mcand_ext = {mcand[DATA_W-1], mcand};
    booth_sum = acc_hi;
    unique case (booth_decode(acc_lo[0], q_m1))
      BOOTH_ADD: booth_sum = acc_hi + mcand_ext;
      BOOTH_SUB: booth_sum = acc_hi - mcand_ext;
      default:   booth_sum = acc_hi;
    endcase
    acc_hi_next = {booth_sum[DATA_W], booth_sum[DATA_W:1]};
    acc_lo_next = {booth_sum[0], acc_lo[DATA_W-1:1]};
  end

  // Booth accumulator {hi, lo, q-1}, initialised to {0, b, 0} on start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_hi <= '0;
      acc_lo <= '0;
      q_m1   <= 1'b0;
      mcand  <= '0;
    end else if (mult_start) begin
      acc_hi <= '0;
      acc_lo <= bus.b_in;
      q_m1   <= 1'b0;
      mcand  <= bus.a_in;
    end else if (mult_step) begin
      acc_hi <= acc_hi_next;
      acc_lo <= acc_lo_next;
      q_m1   <= acc_lo[0];
    end
  end

  div_core #(.DATA_W(DATA_W)) u_div_core (
    .clk       (clk),
    .reset     (reset),
    .load      (div_start),
    .step      (div_step),
    .dividend  (bus.a_in),
    .divisor   (bus.b_in),
    .quotient  (quotient),
    .remainder (remainder)
  );

  // Result buses only change when their own operation completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_hi_q <= '0;
      mult_lo_q <= '0;
      div_hi_q  <= '0;
      div_lo_q  <= '0;
    end else begin
      if (mult_done) begin
        mult_hi_q <= acc_hi_next[DATA_W-1:0];
        mult_lo_q <= acc_lo_next;
      end
      if (div_done) begin
        div_hi_q <= remainder;
        div_lo_q <= quotient;
      end
    end
  end

  // Registered one-cycle completion pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mult_stop_q <= 1'b0;
      div_stop_q  <= 1'b0;
      div_zero_q  <= 1'b0;
    end else begin
      mult_stop_q <= mult_done;
      div_stop_q  <= div_done;
      div_zero_q  <= zero_start;
    end
  end

  assign bus.mult_hi   = mult_hi_q;
  assign bus.mult_lo   = mult_lo_q;
  assign bus.div_hi    = div_hi_q;
  assign bus.div_lo    = div_lo_q;
  assign bus.mult_stop = mult_stop_q;
  assign bus.div_stop  = div_stop_q;
  assign bus.div_zero  = div_zero_q;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomised and directed checks of mult_div_unit against a plain-arithmetic reference model.
`timescale 1ns/1ps
module tb_mult_div_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;

  logic [31:0] exp_mult_hi = '0;
  logic [31:0] exp_mult_lo = '0;
  logic [31:0] exp_div_hi  = '0;
  logic [31:0] exp_div_lo  = '0;

  mult_div_if bus ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  // Reference: full 64-bit signed product.
  function automatic logic [63:0] refProduct(input logic [31:0] a, input logic [31:0] b);
    longint p;
    p = longint'($signed(a)) * longint'($signed(b));
    return p;
  endfunction

  // Reference: truncating division done in 64 bits, so min/-1 simply wraps when cut to 32.
  function automatic logic [63:0] refDivide(input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] qv, rv;
    x = longint'($signed(a));
    y = longint'($signed(b));
    q = x / y;
    r = x % y;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic checkResults(input string tag);
    checkOutput({tag, " mult_hi"}, {32'd0, bus.mult_hi}, {32'd0, exp_mult_hi});
    checkOutput({tag, " mult_lo"}, {32'd0, bus.mult_lo}, {32'd0, exp_mult_lo});
    checkOutput({tag, " div_hi"},  {32'd0, bus.div_hi},  {32'd0, exp_div_hi});
    checkOutput({tag, " div_lo"},  {32'd0, bus.div_lo},  {32'd0, exp_div_lo});
  endtask

  // Present a start for one clock, then scramble operands; returns at the falling edge after the start edge.
  task automatic applyStimulus(input logic mc, input logic dc, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.mult_control = mc;
    bus.div_control  = dc;
    bus.a_in         = a;
    bus.b_in         = b;
    @(negedge clk);
    bus.mult_control = 1'b0;
    bus.div_control  = 1'b0;
    bus.a_in         = $urandom;
    bus.b_in         = $urandom;
  endtask

  task automatic runOp(input logic mc, input logic dc, input logic [31:0] a, input logic [31:0] b,
                       input int repulse_k, input string tag);
    int lat, busy_low, other;
    logic own;
    logic [63:0] r;
    bit is_mult;
    is_mult  = mc;
    lat      = -1;
    busy_low = 0;
    other    = 0;
    applyStimulus(mc, dc, a, b);
    if (!is_mult && b == 32'd0) begin
      checkOutput({tag, " zero pulse"}, {63'd0, bus.div_zero}, 64'd1);
      checkOutput({tag, " zero busy"}, {63'd0, bus.busy}, 64'd0);
      for (int k = 1; k <= 36; k++) begin
        @(negedge clk);
        if (bus.div_stop || bus.div_zero || bus.mult_stop || bus.busy) other++;
      end
      checkOutput({tag, " quiet after zero"}, 64'(other), 64'd0);
    end else begin
      if (is_mult) begin
        r = refProduct(a, b);
        exp_mult_hi = r[63:32];
        exp_mult_lo = r[31:0];
      end else begin
        r = refDivide(a, b);
        exp_div_hi = r[63:32];
        exp_div_lo = r[31:0];
      end
      for (int k = 1; k <= 40 && lat < 0; k++) begin
        @(negedge clk);
        own = is_mult ? bus.mult_stop : bus.div_stop;
        if (own) lat = k;
        else if (!bus.busy) busy_low++;
        if ((is_mult ? bus.div_stop : bus.mult_stop) || bus.div_zero) other++;
        bus.mult_control = (k == repulse_k);
        bus.div_control  = (k == repulse_k);
        if (k == repulse_k) begin
          bus.a_in = $urandom;
          bus.b_in = $urandom;
        end
      end
      bus.mult_control = 1'b0;
      bus.div_control  = 1'b0;
      checkOutput({tag, " latency"}, 64'(lat), is_mult ? 64'd32 : 64'd33);
      checkOutput({tag, " busy while running"}, 64'(busy_low), 64'd0);
      checkOutput({tag, " stray pulse"}, 64'(other), 64'd0);
      checkResults(tag);
      if (lat >= 0) begin
        @(negedge clk);
        own = is_mult ? bus.mult_stop : bus.div_stop;
        checkOutput({tag, " pulse width"}, {63'd0, own}, 64'd0);
      end
    end
  endtask

  initial begin
    int other;
    logic [31:0] ra, rb;
    int kind;
    bus.mult_control = 1'b0;
    bus.div_control  = 1'b0;
    bus.a_in         = '0;
    bus.b_in         = '0;

    #1 reset = 1'b0;
    #11;
    checkResults("reset");
    checkOutput("reset flags", {60'd0, bus.mult_stop, bus.div_stop, bus.div_zero, bus.busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    runOp(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, -1, "mult 7*-3");
    checkOutput("mult 7*-3 hi const", {32'd0, bus.mult_hi}, 64'h0000_0000_FFFF_FFFF);
    checkOutput("mult 7*-3 lo const", {32'd0, bus.mult_lo}, 64'h0000_0000_FFFF_FFEB);

    runOp(1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, -1, "mult min*min");
    checkOutput("mult min*min hi const", {32'd0, bus.mult_hi}, 64'h0000_0000_4000_0000);

    runOp(1'b0, 1'b1, 32'd7, 32'hFFFF_FFFE, -1, "div 7/-2");
    checkOutput("div 7/-2 lo const", {32'd0, bus.div_lo}, 64'h0000_0000_FFFF_FFFD);
    checkOutput("div 7/-2 hi const", {32'd0, bus.div_hi}, 64'h0000_0000_0000_0001);

    runOp(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, -1, "div -7/2");
    checkOutput("div -7/2 hi const", {32'd0, bus.div_hi}, 64'h0000_0000_FFFF_FFFF);

    runOp(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1, "div min/-1");
    checkOutput("div min/-1 lo const", {32'd0, bus.div_lo}, 64'h0000_0000_8000_0000);

    runOp(1'b0, 1'b1, 32'h0000_1234, 32'd1, -1, "div 0x1234/1");
    runOp(1'b0, 1'b1, 32'd99, 32'd0, -1, "div by zero");
    checkOutput("div by zero lo kept", {32'd0, bus.div_lo}, 64'h0000_0000_0000_1234);
    checkResults("div by zero");

    runOp(1'b1, 1'b1, 32'd6, 32'hFFFF_FFFC, -1, "both starts");
    runOp(1'b1, 1'b0, 32'd12345, 32'hFFFF_FFB3, 10, "mult repulse");

    // Abort a divide with an asynchronous reset in the middle of iteration 10.
    applyStimulus(1'b0, 1'b1, 32'd1000, 32'd7);
    repeat (10) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    exp_mult_hi = '0;
    exp_mult_lo = '0;
    exp_div_hi  = '0;
    exp_div_lo  = '0;
    checkResults("async reset");
    checkOutput("async reset flags", {60'd0, bus.mult_stop, bus.div_stop, bus.div_zero, bus.busy}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    other = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.div_stop || bus.mult_stop || bus.busy) other++;
    end
    checkOutput("no stop after abort", 64'(other), 64'd0);
    runOp(1'b1, 1'b0, 32'd3, 32'd5, -1, "mult 3*5");
    checkOutput("mult 3*5 lo const", {32'd0, bus.mult_lo}, 64'd15);

    for (int i = 0; i < 16; i++) begin
      kind = $urandom_range(0, 2);
      ra = $urandom;
      rb = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra >>> $urandom_range(16, 31);
      if ($urandom_range(0, 3) == 0) rb = $signed(rb) >>> $urandom_range(20, 31);
      runOp(kind != 1, kind != 0, ra, rb, -1, $sformatf("random %0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Sequential signed multiplier/divider that sits directly downstream of the multicycle control unit's mult_control/div_control strobes. It consumes the A/B register operands and returns completion flags mult_stop, div_stop and div_zero. Multiplier and divider results are presented on separate hi/lo buses; the datapath's hi/lo select muxes and the HiLo_load strobe pick which pair is written into the HI/LO registers.

Parameters:
DATA_W, 32, operand and result width
CNT_W, 6, iteration counter width (must hold DATA_W)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
mult_control  input  1  start multiply; sampled only in IDLE
div_control  input  1  start divide; sampled only in IDLE
a_in  input  DATA_W  operand A: multiplicand / dividend (rs)
b_in  input  DATA_W  operand B: multiplier / divisor (rt)
mult_hi  output  DATA_W  upper half of signed product
mult_lo  output  DATA_W  lower half of signed product
div_hi  output  DATA_W  signed remainder
div_lo  output  DATA_W  signed quotient
mult_stop  output  1  one-cycle pulse: multiply result valid
div_stop  output  1  one-cycle pulse: divide result valid
div_zero  output  1  one-cycle pulse: divisor was zero
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset low, asynchronous): state IDLE, counter 0, all result buses 0, mult_stop, div_stop, div_zero and busy all 0. Reset that arrives during an operation aborts it; no stop pulse is issued afterwards.
- States: IDLE, MULT, DIV, DIV_FIX.
- IDLE behaviour:
  - mult_control=1: latch a_in and b_in, go to MULT, counter=0. mult_control has priority if both starts are high in the same cycle; div_control is then ignored.
  - div_control=1 with b_in==0: stay in IDLE, pulse div_zero in the next cycle, leave div_hi and div_lo unchanged, no div_stop.
  - div_control=1 with b_in!=0: latch |a_in|, |b_in| and both sign bits, go to DIV, counter=0.
- Start strobes are ignored while busy.
- MULT: radix-2 Booth. The 2*DATA_W+1 bit accumulator is {hi, lo, q-1}, initialised {0, b, 0}.
  - Each cycle: examine lo[0] and q-1. On 10 subtract a from hi; on 01 add a to hi. Then arithmetic-shift the whole accumulator right by 1.
  - After DATA_W iterations (counter reaches DATA_W-1), register mult_hi and mult_lo, assert mult_stop for exactly one cycle, return to IDLE.
  - Latency: mult_stop is high in the cycle after the 32nd edge following the start edge.
- DIV: restoring division on magnitudes, one quotient bit per cycle, DATA_W cycles, then one DIV_FIX cycle.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend (truncation toward zero).
  - DIV_FIX registers div_hi and div_lo, pulses div_stop for one cycle, returns to IDLE.
  - Latency: 33 edges after the start edge.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000, remainder 0 (wraps, no flag).
- Magnitude computation uses DATA_W+1 bits so |0x80000000| is exact.
- Result buses hold their value until the next completion of the same operation. The other operation's buses are never disturbed.
- Stop and zero pulses are registered outputs, never combinational.

Decomposition:
- Shared package mult_div_pkg: state encoding constants (IDLE=0, MULT=1, DIV=2, DIV_FIX=3), DATA_W default, Booth op codes.
- One sub-module is natural: div_core (restoring iteration datapath plus sign fix). Booth multiply stays inline in mult_div_unit.

Test Plan:
- mult a=7, b=0xFFFFFFFD (-3) -> mult_hi=0xFFFFFFFF, mult_lo=0xFFFFFFEB; mult_stop a single cycle, 32 cycles after start; busy high throughout.
- mult a=b=0x80000000 -> mult_hi=0x40000000, mult_lo=0x00000000; div_hi and div_lo unchanged.
- div a=7, b=0xFFFFFFFE (-2) -> div_lo=0xFFFFFFFD, div_hi=0x00000001; div_stop 33 cycles after start. Also div a=0xFFFFFFF9 (-7), b=2 -> div_lo=0xFFFFFFFD, div_hi=0xFFFFFFFF.
- div b=0 with prior div_lo=0x1234 -> div_zero pulse the next cycle, no div_stop, div_lo stays 0x1234, busy stays 0.
- mult_control and div_control high together -> only multiply runs, div_stop never pulses. Re-pulse mult_control mid-operation -> ignored, result matches the first operands.
- Drive reset low asynchronously at iteration 10 of a divide -> all outputs 0 immediately, no div_stop afterwards; a fresh mult 3*5 then gives mult_lo=15.
